// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one 8N1 UART transmit line and
// its baud generator among N_REQ byte requesters. The generator's enable
// (bps_start) is held for a whole frame. Each bps_clk pulse advances the
// frame by one bit.
module uart_tx_sched #(
  parameter int N_REQ = 4,
  parameter int IW    = 2            // must equal $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  input  logic               bps_clk,
  output logic [N_REQ-1:0]   grant,
  output logic               done,
  output logic [IW-1:0]      done_id,
  output logic               busy,
  output logic               bps_start,
  output logic               txd
);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [IW-1:0]    last_q, last_d;
  logic             txd_d, bps_d, done_d;
  logic [IW-1:0]    done_id_d;
  logic [N_REQ-1:0] grant_d;

  logic             win_vld;
  logic [IW-1:0]    win_id;
  logic [7:0]       win_byte;
  logic [2:0]       bit_idx;
  int               idx;

  // Round-robin pick: scan from last winner + 1, wrapping, first active req wins
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    idx      = 0;
    win_byte = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req[idx[IW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++)
      if (win_id == IW'(i)) win_byte = data[8*i +: 8];
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    shreg_d   = shreg_q;
    cur_id_d  = cur_id_q;
    last_d    = last_q;
    txd_d     = txd;
    bps_d     = bps_start;
    grant_d   = '0;
    done_d    = 1'b0;
    done_id_d = done_id;
    // pcnt 1..8 selects data bits 0..7 (pcnt 8 wraps to index 7)
    bit_idx   = pcnt_q[2:0] - 3'd1;
    case (state_q)
      IDLE: begin
        // Idle is always at least one cycle with bps_start low so the
        // generator restarts its count for every frame; stray bps_clk ignored.
        txd_d = 1'b1;
        bps_d = 1'b0;
        if (win_vld) begin
          shreg_d          = win_byte;
          cur_id_d         = win_id;
          last_d           = win_id;
          grant_d[win_id]  = 1'b1;
          bps_d            = 1'b1;
          pcnt_d           = '0;
          state_d          = FRAME;
        end
      end
      FRAME: begin
        if (bps_clk) begin
          pcnt_d = pcnt_q + 4'd1;
          if (pcnt_q == 4'd0)      txd_d = 1'b0;              // start bit
          else if (pcnt_q <= 4'd8) txd_d = shreg_q[bit_idx];  // data, LSB first
          else if (pcnt_q == 4'd9) txd_d = 1'b1;              // stop bit
          else begin                                          // stop bit elapsed
            bps_d     = 1'b0;
            done_d    = 1'b1;
            done_id_d = cur_id_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      shreg_q   <= '0;
      cur_id_q  <= '0;
      last_q    <= IW'(N_REQ - 1);
      txd       <= 1'b1;
      bps_start <= 1'b0;
      grant     <= '0;
      done      <= 1'b0;
      done_id   <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      shreg_q   <= shreg_d;
      cur_id_q  <= cur_id_d;
      last_q    <= last_d;
      txd       <= txd_d;
      bps_start <= bps_d;
      grant     <= grant_d;
      done      <= done_d;
      done_id   <= done_id_d;
    end
  end

  assign busy = (state_q == FRAME);

endmodule
